// File: rtl/control_hazard_unit.sv
// control_hazard_unit
//   Decodes the ID instruction into the control bundle, registers it into ID/EX,
//   and resolves pipeline hazards: load-use bubbles, branch/jump flushes, and
//   stalls while the fixed-latency mult/div unit is busy.
// Ports:
//   clk, reset            pipeline clock, synchronous active-high reset
//   enable                global advance; 0 holds every register
//   opcode, funct         ID instruction fields [31:26] and [5:0]
//   id_rs, id_rt          ID source register fields
//   branch_taken          branch resolved taken in EX
//   stall, flush_ifid     combinational PC/IF-ID hold and IF-ID clear
//   ex_*                  registered ID/EX control bundle and rt
//   md_busy               mult/div latency counter non-zero
module control_hazard_unit #(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned MD_LAT  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               branch_taken,
  output logic               stall,
  output logic               flush_ifid,
  output logic               ex_regdst,
  output logic               ex_branch,
  output logic               ex_memread,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic               ex_regwrite,
  output logic               ex_jump,
  output logic               ex_shiftc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [REG_W-1:0]   ex_rt,
  output logic               md_busy
);

  // Bundle order: {regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, jump, shiftc}
  logic [8:0]         ctrl_d, ctrl_q;
  logic [ALUOP_W-1:0] aluop_d, aluop_q;
  logic [REG_W-1:0]   rt_q;
  logic [3:0]         md_cnt_q;

  logic is_rtype, uses_rt, md_op, hilo_rd;
  logic load_use, md_haz, issue;

  assign is_rtype = (opcode == 6'b000000);

  always_comb begin
    ctrl_d  = 9'b0;
    aluop_d = '0;
    uses_rt = 1'b0;
    unique case (opcode)
      6'b000000: begin
        ctrl_d[8] = 1'b1;
        ctrl_d[2] = 1'b1;
        ctrl_d[0] = (funct == 6'b000000) || (funct == 6'b000010) || (funct == 6'b000011);
        aluop_d   = ALUOP_W'(2'b10);
        uses_rt   = 1'b1;
      end
      6'b100011, 6'b100000, 6'b100001, 6'b100111, 6'b100100, 6'b100101: begin
        ctrl_d = 9'b001101100;
      end
      6'b101011, 6'b101001, 6'b101000: begin
        ctrl_d  = 9'b000011000;
        uses_rt = 1'b1;
      end
      6'b001100, 6'b001101, 6'b001110, 6'b001000, 6'b001010, 6'b001111: begin
        ctrl_d  = 9'b000001100;
        aluop_d = ALUOP_W'(2'b10);
      end
      6'b000100, 6'b000101: begin
        ctrl_d  = 9'b010000000;
        aluop_d = ALUOP_W'(2'b01);
        uses_rt = 1'b1;
      end
      6'b000010: begin
        ctrl_d = 9'b000000010;
      end
      default: ;
    endcase
  end

  assign md_op   = is_rtype && (funct[5:2] == 4'b0110);
  assign hilo_rd = is_rtype && ((funct == 6'b010000) || (funct == 6'b010010));

  assign load_use = ex_memread && (rt_q != '0) &&
                    ((rt_q == id_rs) || (uses_rt && (rt_q == id_rt)));
  assign md_haz   = md_busy && (md_op || hilo_rd);

  assign flush_ifid = branch_taken || ex_jump;
  assign stall      = (load_use || md_haz) && !flush_ifid;
  // Instruction actually enters EX this edge.
  assign issue      = enable && !flush_ifid && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      aluop_q  <= '0;
      rt_q     <= '0;
      md_cnt_q <= '0;
    end else if (enable) begin
      if (issue) begin
        ctrl_q  <= ctrl_d;
        aluop_q <= aluop_d;
        rt_q    <= id_rt;
      end else begin
        ctrl_q  <= '0;
        aluop_q <= '0;
        rt_q    <= '0;
      end
      if (issue && md_op) begin
        md_cnt_q <= 4'(MD_LAT);
      end else if (md_cnt_q != 4'd0) begin
        md_cnt_q <= md_cnt_q - 4'd1;
      end
    end
  end

  assign {ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite,
          ex_alusrc, ex_regwrite, ex_jump, ex_shiftc} = ctrl_q;
  assign ex_aluop = aluop_q;
  assign ex_rt    = rt_q;
  assign md_busy  = (md_cnt_q != 4'd0);

endmodule

// File: tb/tb_control_hazard_unit.sv
module tb_control_hazard_unit;

  logic       clk = 1'b0;
  logic       reset, enable, branch_taken;
  logic [5:0] opcode, funct;
  logic [4:0] id_rs, id_rt;
  logic       stall, flush_ifid, md_busy;
  logic       ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite;
  logic       ex_alusrc, ex_regwrite, ex_jump, ex_shiftc;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rt;

  control_hazard_unit #(.REG_W(5), .ALUOP_W(2), .MD_LAT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .opcode(opcode), .funct(funct),
    .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
    .stall(stall), .flush_ifid(flush_ifid),
    .ex_regdst(ex_regdst), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_jump(ex_jump), .ex_shiftc(ex_shiftc),
    .ex_aluop(ex_aluop), .ex_rt(ex_rt), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Control bundle {regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, jump, shiftc}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_R    = 9'b100000100;
  localparam logic [8:0] C_SLL  = 9'b100000101;
  localparam logic [8:0] C_LW   = 9'b001101100;
  localparam logic [8:0] C_SW   = 9'b000011000;
  localparam logic [8:0] C_ORI  = 9'b000001100;
  localparam logic [8:0] C_BEQ  = 9'b010000000;
  localparam logic [8:0] C_J    = 9'b000000010;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SLL = 6'b000000, F_MULT = 6'b011000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  typedef struct {
    string       tag;
    logic [18:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  function automatic logic [18:0] ev(input logic s, input logic f, input logic b,
                                     input logic [8:0] c, input logic [1:0] a,
                                     input logic [4:0] rt);
    return {s, f, b, c, a, rt};
  endfunction

  // Inputs are driven just after a falling edge and checked 1 time unit later,
  // so combinational outputs see the new inputs and registered ones the last edge.
  task automatic step(input string tag, input logic rst, input logic en,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic bt,
                      input logic [18:0] exp);
    sb_t e;
    logic [18:0] obs;
    reset = rst; enable = en; opcode = op; funct = fn;
    id_rs = rs; id_rt = rt; branch_taken = bt;
    sb_q.push_back('{tag: tag, exp: exp});
    #1;
    e = sb_q.pop_front();
    obs = {stall, flush_ifid, md_busy, ex_regdst, ex_branch, ex_memread, ex_memtoreg,
           ex_memwrite, ex_alusrc, ex_regwrite, ex_jump, ex_shiftc, ex_aluop, ex_rt};
    vectors++;
    assert (obs === e.exp) else begin
      miscompares++;
      $error("FAIL %s: got %b want %b", e.tag, obs, e.exp);
    end
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; opcode = OP_LW; funct = '0;
    id_rs = '0; id_rt = 5'd5; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    step("reset",       1, 1, OP_LW,  F_ADD,  5'd1, 5'd5, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("lw_id",       0, 1, OP_LW,  F_ADD,  5'd1, 5'd5, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("lu_stall",    0, 1, OP_R,   F_ADD,  5'd5, 5'd6, 0, ev(1,0,0, C_LW,   2'b00, 5'd5));
    step("lu_bubble",   0, 1, OP_R,   F_ADD,  5'd5, 5'd6, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("add_issued",  0, 1, OP_LW,  F_ADD,  5'd2, 5'd0, 0, ev(0,0,0, C_R,    2'b10, 5'd6));
    step("lw_rt0_nost", 0, 1, OP_R,   F_ADD,  5'd0, 5'd0, 0, ev(0,0,0, C_LW,   2'b00, 5'd0));
    step("lw_rt7",      0, 1, OP_LW,  F_ADD,  5'd3, 5'd7, 0, ev(0,0,0, C_R,    2'b10, 5'd0));
    step("sw_rt_stall", 0, 1, OP_SW,  F_ADD,  5'd1, 5'd7, 0, ev(1,0,0, C_LW,   2'b00, 5'd7));
    step("sw_bubble",   0, 1, OP_SW,  F_ADD,  5'd1, 5'd7, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("sw_issued",   0, 1, OP_LW,  F_ADD,  5'd0, 5'd9, 0, ev(0,0,0, C_SW,   2'b00, 5'd7));
    step("ori_no_rt",   0, 1, OP_ORI, F_ADD,  5'd1, 5'd9, 0, ev(0,0,0, C_LW,   2'b00, 5'd9));
    step("mult_id",     0, 1, OP_R,   F_MULT, 5'd2, 5'd3, 0, ev(0,0,0, C_ORI,  2'b10, 5'd9));
    step("mflo_busy4",  0, 1, OP_R,   F_MFLO, 5'd0, 5'd0, 0, ev(1,0,1, C_R,    2'b10, 5'd3));
    step("mflo_busy3",  0, 1, OP_R,   F_MFLO, 5'd0, 5'd0, 0, ev(1,0,1, C_NONE, 2'b00, 5'd0));
    step("mflo_busy2",  0, 1, OP_R,   F_MFLO, 5'd0, 5'd0, 0, ev(1,0,1, C_NONE, 2'b00, 5'd0));
    step("mflo_busy1",  0, 1, OP_R,   F_MFLO, 5'd0, 5'd0, 0, ev(1,0,1, C_NONE, 2'b00, 5'd0));
    step("mflo_free",   0, 1, OP_R,   F_MFLO, 5'd0, 5'd0, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("mflo_issued", 0, 1, OP_BAD, F_ADD,  5'd0, 5'd0, 0, ev(0,0,0, C_R,    2'b10, 5'd0));
    step("bad_op_zero", 0, 1, OP_LW,  F_ADD,  5'd0, 5'd4, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("lu_vs_flush", 0, 1, OP_R,   F_ADD,  5'd4, 5'd0, 1, ev(0,1,0, C_LW,   2'b00, 5'd4));
    step("flush_bubbl", 0, 1, OP_J,   F_ADD,  5'd0, 5'd0, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("j_in_ex",     0, 1, OP_BEQ, F_ADD,  5'd1, 5'd2, 0, ev(0,1,0, C_J,    2'b00, 5'd0));
    step("j_flush_end", 0, 1, OP_BEQ, F_ADD,  5'd1, 5'd2, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("beq_issued",  0, 1, OP_R,   F_SLL,  5'd0, 5'd3, 0, ev(0,0,0, C_BEQ,  2'b01, 5'd2));
    step("sll_issued",  0, 1, OP_R,   F_MULT, 5'd0, 5'd1, 0, ev(0,0,0, C_SLL,  2'b10, 5'd3));
    step("hold_en0_a",  0, 0, OP_LW,  F_ADD,  5'd0, 5'd8, 0, ev(0,0,1, C_R,    2'b10, 5'd1));
    step("hold_en0_b",  0, 0, OP_LW,  F_ADD,  5'd0, 5'd8, 0, ev(0,0,1, C_R,    2'b10, 5'd1));
    step("resume_en",   0, 1, OP_R,   F_ADD,  5'd0, 5'd0, 0, ev(0,0,1, C_R,    2'b10, 5'd1));
    step("cnt3",        0, 1, OP_R,   F_ADD,  5'd0, 5'd0, 0, ev(0,0,1, C_R,    2'b10, 5'd0));
    step("rst_at_cnt2", 1, 1, OP_R,   F_ADD,  5'd0, 5'd0, 0, ev(0,0,1, C_R,    2'b10, 5'd0));
    step("rst_cleared", 1, 1, OP_R,   F_ADD,  5'd0, 5'd0, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("post_reset",  0, 1, OP_R,   F_ADD,  5'd0, 5'd0, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));
    step("flush_mult",  0, 1, OP_R,   F_MULT, 5'd0, 5'd0, 1, ev(0,1,0, C_R,    2'b10, 5'd0));
    step("mult_dropped",0, 1, OP_BAD, F_ADD,  5'd0, 5'd0, 0, ev(0,0,0, C_NONE, 2'b00, 5'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
